i2s_tx: RTL and testbench

Downstream consumer of the 16-bit signed tone/audio sample generators. It accepts stereo sample frames over a valid/ready handshake into a one-frame holding buffer and serializes them onto a Philips-format I2S link (BCLK, LRCK, SDATA) toward the board DAC. BCLK and LRCK are derived from the system clock by an integer divider. The block sits between the sample source and the codec pins.

---
 rtl/i2s_tx.sv | 133 +++++++++++++
 tb/tb_i2s_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx
// Purpose  : Stereo frame holding buffer feeding a Philips-format I2S
//            serializer (BCLK/LRCK/SDATA) with an integer clock divider.
//            Define I2S_UNDERRUN_HOLD_EN to repeat the last frame on underrun.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_tx #(
    parameter int CLK_DIV      = 4,
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_BITS    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [SAMPLE_WIDTH-1:0] s_left,
    input  logic [SAMPLE_WIDTH-1:0] s_right,
    output logic                    i2s_bclk,
    output logic                    i2s_lrck,
    output logic                    i2s_data,
    output logic                    underrun
);

    localparam int c_FRAME_BITS = 2 * SLOT_BITS;
    localparam int c_PAD        = SLOT_BITS - SAMPLE_WIDTH;
    localparam int c_DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_K_W        = $clog2(c_FRAME_BITS);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);
    localparam logic [c_K_W-1:0]   c_K_LAST   = c_K_W'(c_FRAME_BITS - 1);
    localparam logic [c_K_W-1:0]   c_K_RIGHT  = c_K_W'(SLOT_BITS);
    localparam logic [c_K_W-1:0]   c_K_ONE    = c_K_W'(1);

    logic [c_DIV_W-1:0]      r_div;
    logic [c_K_W-1:0]        r_k;
    logic                    r_bclk;
    logic                    r_lrck;
    logic                    r_data;
    logic                    r_ready;
    logic                    r_underrun;
    logic                    r_full;
    logic [c_FRAME_BITS-1:0] r_buf;
    logic [c_FRAME_BITS-1:0] r_shift;
`ifdef I2S_UNDERRUN_HOLD_EN
    logic [c_FRAME_BITS-1:0] r_last;
`endif

    logic [SLOT_BITS-1:0]    w_left_slot;
    logic [SLOT_BITS-1:0]    w_right_slot;
    logic [c_FRAME_BITS-1:0] w_frame_in;
    logic                    w_bclk_fall;
    logic                    w_xfer;
    logic                    w_take;
    logic                    w_full_next;

    // Samples sit MSB-aligned in their slot; the shift register emits MSB first.
    assign w_left_slot  = SLOT_BITS'(s_left) << c_PAD;
    assign w_right_slot = SLOT_BITS'(s_right) << c_PAD;
    assign w_frame_in   = {w_left_slot, w_right_slot};

    assign w_bclk_fall = (r_div == c_DIV_LAST) && r_bclk;
    assign w_xfer      = s_valid && r_ready;
    assign w_take      = w_bclk_fall && (r_k == '0) && r_full;
    assign w_full_next = (r_full && !w_take) || w_xfer;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div      <= '0;
            r_k        <= '0;
            r_bclk     <= 1'b0;
            r_lrck     <= 1'b0;
            r_data     <= 1'b0;
            r_ready    <= 1'b0;
            r_underrun <= 1'b0;
            r_full     <= 1'b0;
            r_buf      <= '0;
            r_shift    <= '0;
`ifdef I2S_UNDERRUN_HOLD_EN
            r_last     <= '0;
`endif
        end else begin
            r_underrun <= 1'b0;
            r_full     <= w_full_next;
            r_ready    <= !w_full_next;

            if (w_xfer) begin
                r_buf <= w_frame_in;
            end

            if (r_div == c_DIV_LAST) begin
                r_div  <= '0;
                r_bclk <= !r_bclk;
            end else begin
                r_div <= r_div + c_DIV_ONE;
            end

            if (w_bclk_fall) begin
                // The MSB at k=0 is still the previous frame's last bit: the Philips one-bit lag.
                r_data <= r_shift[c_FRAME_BITS-1];
                r_lrck <= (r_k >= c_K_RIGHT);
                r_k    <= (r_k == c_K_LAST) ? '0 : r_k + c_K_ONE;
                if (r_k == '0) begin
                    if (r_full) begin
                        r_shift <= r_buf;
`ifdef I2S_UNDERRUN_HOLD_EN
                        r_last  <= r_buf;
`endif
                    end else begin
                        r_underrun <= 1'b1;
`ifdef I2S_UNDERRUN_HOLD_EN
                        r_shift    <= r_last;
`else
                        r_shift    <= '0;
`endif
                    end
                end else begin
                    r_shift <= {r_shift[c_FRAME_BITS-2:0], 1'b0};
                end
            end
        end
    end

    assign s_ready  = r_ready;
    assign i2s_bclk = r_bclk;
    assign i2s_lrck = r_lrck;
    assign i2s_data = r_data;
    assign underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_tx
// Purpose  : Scoreboard bench for i2s_tx: frame-level reference model feeds an
//            expected bit queue that a BCLK-falling-edge monitor drains.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_tx;

    localparam int CLK_DIV = 4;
    localparam int SW      = 16;
    localparam int SLOT    = 16;
    localparam int NBITS   = 2 * SLOT;
    localparam int PERIOD  = 4 * SLOT * CLK_DIV;
    localparam int FIRST   = 2 * CLK_DIV;
`ifdef I2S_UNDERRUN_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s_valid = 1'b0;
    logic [SW-1:0] s_left = '0;
    logic [SW-1:0] s_right = '0;
    logic          s_ready;
    logic          i2s_bclk;
    logic          i2s_lrck;
    logic          i2s_data;
    logic          underrun;

    i2s_tx #(
        .CLK_DIV     (CLK_DIV),
        .SAMPLE_WIDTH(SW),
        .SLOT_BITS   (SLOT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_left  (s_left),
        .s_right (s_right),
        .i2s_bclk(i2s_bclk),
        .i2s_lrck(i2s_lrck),
        .i2s_data(i2s_data),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [SW-1:0] l; logic [SW-1:0] r; } frame_t;
    typedef struct packed { logic lrck; logic data; logic und; } bit_t;

    bit_t   q_exp[$];
    frame_t pend[$];
    frame_t last_fr = '0;
    logic   last_bit = 1'b0;
    int     cyc = 0;
    logic   ready_exp = 1'b0;
    logic   in_reset = 1'b1;
    int     total = 0;
    int     bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Frame bit j of a stereo frame: left slot then right slot, MSB first, zero padded.
    function automatic logic fbit(input frame_t f, input int j);
        logic [SW-1:0] s;
        int idx;
        if (j < SLOT) begin
            s = f.l; idx = j;
        end else begin
            s = f.r; idx = j - SLOT;
        end
        if (idx < SW) return s[SW-1-idx];
        return 1'b0;
    endfunction

    // Reference model: frame boundaries fall at fixed clk counts after reset release.
    always @(posedge clk) begin
        frame_t fr;
        logic   und;
        logic   xfer;
        if (reset) begin
            in_reset  = 1'b1;
            q_exp.delete();
            pend.delete();
            last_fr   = '0;
            last_bit  = 1'b0;
            cyc       = 0;
            ready_exp = 1'b0;
        end else begin
            in_reset = 1'b0;
            xfer = s_valid && ready_exp;
            cyc++;
            if (cyc >= FIRST && ((cyc - FIRST) % PERIOD) == 0) begin
                und = (pend.size() == 0);
                if (!und) begin
                    fr = pend.pop_front();
                    last_fr = fr;
                end else begin
                    fr = HOLD ? last_fr : '0;
                end
                q_exp.push_back('{lrck: 1'b0, data: last_bit, und: und});
                for (int k = 1; k < NBITS; k++)
                    q_exp.push_back('{lrck: (k >= SLOT), data: fbit(fr, k - 1), und: 1'b0});
                last_bit = fbit(fr, NBITS - 1);
            end
            if (xfer) pend.push_back('{l: s_left, r: s_right});
            ready_exp = (pend.size() == 0);
        end
    end

    // Monitor: every negedge checks handshake and stability; each BCLK fall pops one bit.
    logic prev_bclk = 1'b0;
    logic cur_lrck = 1'b0;
    logic cur_data = 1'b0;
    int   last_fall = -1;
    always @(negedge clk) begin
        bit_t e;
        if (in_reset) begin
            chk("reset_outputs", {i2s_bclk, i2s_lrck, i2s_data, s_ready, underrun}, 0);
            prev_bclk = 1'b0;
            cur_lrck  = 1'b0;
            cur_data  = 1'b0;
            last_fall = -1;
        end else begin
            chk("s_ready", s_ready, ready_exp);
            if (prev_bclk && !i2s_bclk) begin
                if (last_fall >= 0) chk("bclk_period", cyc - last_fall, 2 * CLK_DIV);
                last_fall = cyc;
                if (q_exp.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL no_expected_bit: got fall at cycle %0d expected none", cyc);
                end else begin
                    e = q_exp.pop_front();
                    cur_lrck = e.lrck;
                    cur_data = e.data;
                    chk("lrck", i2s_lrck, e.lrck);
                    chk("data", i2s_data, e.data);
                    chk("underrun", underrun, e.und);
                end
            end else begin
                chk("underrun_quiet", underrun, 0);
                chk("lrck_hold", i2s_lrck, cur_lrck);
                chk("data_hold", i2s_data, cur_data);
            end
            prev_bclk = i2s_bclk;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [SW-1:0] l, input logic [SW-1:0] r);
        logic rd;
        int   budget;
        budget  = 0;
        s_valid = 1'b1;
        s_left  = l;
        s_right = r;
        forever begin
            rd = s_ready;
            tick(1);
            if (rd) break;
            budget++;
            if (budget > 2000) begin
                total++;
                bad++;
                $display("FAIL send_timeout: got no s_ready expected acceptance within 2000 clks");
                break;
            end
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        tick(n);
        reset = 1'b0;
    endtask

    initial begin
        int w;
        tick(5);
        reset = 1'b0;
        tick(600);

        send(16'h8001, 16'h7FFE);
        s_valid = 1'b0;
        tick(600);

        tick(100);
        do_reset(3);
        send(16'hA5A5, 16'h0F0F);
        send(16'h1357, 16'h2468);
        send(16'hFFFF, 16'h0001);
        s_valid = 1'b0;
        tick(1000);

        // Offer a frame exactly on the clk of a k=0 load with an empty buffer.
        w = 0;
        while (!((cyc + 1) >= FIRST && ((cyc + 1 - FIRST) % PERIOD) == 0)) begin
            tick(1);
            w++;
            if (w > 2 * PERIOD) begin
                total++;
                bad++;
                $display("FAIL collision_wait: got no boundary expected one within %0d clks", 2 * PERIOD);
                break;
            end
        end
        send(16'h5A5A, 16'hC3C3);
        s_valid = 1'b0;
        tick(600);

        send(16'h1234, 16'hABCD);
        s_valid = 1'b0;
        tick(1100);

        for (int i = 0; i < 20; i++) begin
            tick($urandom_range(0, 350));
            send(SW'($urandom), SW'($urandom));
            s_valid = 1'b0;
        end
        tick(600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
